// File: rtl/letter_sequencer.sv
// Plays a fixed ten-letter message ("ABDUL-JOSE") as 4-bit codes for a 7-segment decoder.
// Each letter is shown for SHOW_TICKS cycles, followed by GAP_TICKS blank cycles.
module letter_sequencer #(
    parameter int SHOW_TICKS = 3,
    parameter int GAP_TICKS  = 1,
    parameter int MSG_LEN    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       loop_en,
    output logic [3:0] letter,
    output logic       letter_valid,
    output logic       busy,
    output logic       msg_done
);

    localparam int MAX_T = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [3:0]       LAST_IDX  = 4'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [3:0] rom_code(input logic [3:0] i);
        case (i)
            4'd0:    return 4'd0;
            4'd1:    return 4'd1;
            4'd2:    return 4'd2;
            4'd3:    return 4'd3;
            4'd4:    return 4'd4;
            4'd5:    return 4'd5;
            4'd6:    return 4'd6;
            4'd7:    return 4'd7;
            4'd8:    return 4'd8;
            4'd9:    return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    state_t           r_state, w_state;
    logic [3:0]       r_idx, w_idx;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [3:0]       w_letter;
    logic             w_valid, w_busy, w_done;
    logic             w_letter_end;

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_cnt        = r_cnt;
        w_letter     = letter;
        w_valid      = letter_valid;
        w_busy       = busy;
        w_done       = 1'b0;
        w_letter_end = 1'b0;

        if (abort) begin
            w_state = IDLE;
            w_idx   = 4'd0;
            w_cnt   = '0;
            w_valid = 1'b0;
            w_busy  = 1'b0;
        end else if (!pause) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state  = SHOW;
                        w_idx    = 4'd0;
                        w_cnt    = '0;
                        w_letter = rom_code(4'd0);
                        w_valid  = 1'b1;
                        w_busy   = 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_cnt = '0;
                        if (GAP_TICKS == 0) begin
                            w_letter_end = 1'b1;
                        end else begin
                            w_state = GAP;
                            w_valid = 1'b0;
                        end
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt        = '0;
                        w_letter_end = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_idx   = 4'd0;
                    w_cnt   = '0;
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                end
            endcase

            // A letter has finished: advance, wrap for looping, or retire to IDLE.
            if (w_letter_end) begin
                if (r_idx != LAST_IDX) begin
                    w_state  = SHOW;
                    w_idx    = r_idx + 4'd1;
                    w_letter = rom_code(r_idx + 4'd1);
                    w_valid  = 1'b1;
                end else begin
                    w_done = 1'b1;
                    w_idx  = 4'd0;
                    if (loop_en) begin
                        w_state  = SHOW;
                        w_letter = rom_code(4'd0);
                        w_valid  = 1'b1;
                    end else begin
                        w_state = IDLE;
                        w_valid = 1'b0;
                        w_busy  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= 4'd0;
            r_cnt        <= '0;
            letter       <= 4'd0;
            letter_valid <= 1'b0;
            busy         <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_cnt        <= w_cnt;
            letter       <= w_letter;
            letter_valid <= w_valid;
            busy         <= w_busy;
            msg_done     <= w_done;
        end
    end

endmodule

// File: tb/tb_letter_sequencer.sv
// Bench for letter_sequencer: two configurations share stimulus and are checked every
// cycle against a position-based model, plus literal timing points of the message.
module tb_letter_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0, loop_en = 1'b0;

    logic [3:0] letter_a, letter_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    letter_sequencer u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause), .loop_en(loop_en),
        .letter(letter_a), .letter_valid(valid_a), .busy(busy_a), .msg_done(done_a)
    );

    letter_sequencer #(.SHOW_TICKS(3), .GAP_TICKS(0), .MSG_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause), .loop_en(loop_en),
        .letter(letter_b), .letter_valid(valid_b), .busy(busy_b), .msg_done(done_b)
    );

    logic [3:0] d_letter[2];
    logic       d_valid[2], d_busy[2], d_done[2];
    assign d_letter[0] = letter_a;
    assign d_letter[1] = letter_b;
    assign d_valid[0]  = valid_a;
    assign d_valid[1]  = valid_b;
    assign d_busy[0]   = busy_a;
    assign d_busy[1]   = busy_b;
    assign d_done[0]   = done_a;
    assign d_done[1]   = done_b;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: a playing message is a position counted in unpaused cycles since start.
    int SH[2] = '{3, 3};
    int GP[2] = '{1, 0};
    int LN[2] = '{10, 1};
    bit m_act[2];
    int m_pos[2];
    bit m_done[2];
    bit m_rst[2];
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            m_rst[i]  = 1'b0;
            if (rst) begin
                m_act[i] = 1'b0;
                m_pos[i] = 0;
                m_rst[i] = 1'b1;
            end else if (abort) begin
                m_act[i] = 1'b0;
                m_pos[i] = 0;
            end else if (pause) begin
                m_act[i] = m_act[i];
            end else if (!m_act[i]) begin
                if (start) begin
                    m_act[i] = 1'b1;
                    m_pos[i] = 0;
                end
            end else begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == LN[i] * (SH[i] + GP[i])) begin
                    m_done[i] = 1'b1;
                    m_pos[i]  = 0;
                    if (!loop_en) m_act[i] = 1'b0;
                end
            end
        end
        if (rst) m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            for (int i = 0; i < 2; i++) begin
                int per;
                bit exp_valid;
                per = SH[i] + GP[i];
                exp_valid = m_act[i] && ((m_pos[i] % per) < SH[i]);
                check($sformatf("u%0d busy", i), int'(d_busy[i]), int'(m_act[i]));
                check($sformatf("u%0d letter_valid", i), int'(d_valid[i]), int'(exp_valid));
                check($sformatf("u%0d msg_done", i), int'(d_done[i]), int'(m_done[i]));
                if (m_act[i])
                    check($sformatf("u%0d letter", i), int'(d_letter[i]), m_pos[i] / per);
                else if (m_rst[i])
                    check($sformatf("u%0d letter after rst", i), int'(d_letter[i]), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    int got0, got1, bcnt, drops, d1, d2;

    initial begin
        repeat (3) step();
        check("reset letter", int'(letter_a), 0);
        check("reset busy", int'(busy_a), 0);
        rst = 1'b0;
        step();

        // Plain message, no loop.
        start = 1'b1;
        step();
        start = 1'b0;
        check("A first letter", int'(letter_a), 0);
        check("A first valid", int'(valid_a), 1);
        got0 = -1; got1 = -1; bcnt = 1;
        for (int n = 1; n <= 50; n++) begin
            step();
            if (n == 13) check("A letter3", int'(letter_a), 3);
            if (n == 15) begin
                check("A gap valid", int'(valid_a), 0);
                check("A gap letter held", int'(letter_a), 3);
            end
            if (busy_a) bcnt++;
            if (done_a && got0 < 0) got0 = n;
            if (done_b && got1 < 0) got1 = n;
        end
        check("A done cycle", got0, 40);
        check("A busy cycles", bcnt, 40);
        check("A short-msg done cycle", got1, 3);

        // Pause 5 cycles during second cycle of letter 3.
        start = 1'b1;
        step();
        start = 1'b0;
        got0 = -1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 16) begin
                check("B paused letter", int'(letter_a), 3);
                check("B paused valid", int'(valid_a), 1);
            end
            if (done_a && got0 < 0) got0 = n;
            if (n == 13) pause = 1'b1;
            if (n == 18) pause = 1'b0;
        end
        check("B done cycle", got0, 45);

        // Abort during the gap of letter 6.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            step();
            if (n == 27) begin
                check("C gap6 valid", int'(valid_a), 0);
                check("C gap6 letter", int'(letter_a), 6);
                abort = 1'b1;
            end
            if (n == 28) begin
                check("C abort busy", int'(busy_a), 0);
                check("C abort valid", int'(valid_a), 0);
                check("C abort done", int'(done_a), 0);
                abort = 1'b0;
            end
        end
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("C replay letter", int'(letter_a), 0);
        check("C replay valid", int'(valid_a), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Looping playback.
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        d1 = -1; d2 = -1; drops = 0;
        for (int n = 1; n <= 85; n++) begin
            step();
            if (!busy_a) drops++;
            if (done_a) begin
                if (d1 < 0) d1 = n;
                else if (d2 < 0) d2 = n;
            end
            if (n == 40) check("D wrap letter", int'(letter_a), 0);
        end
        check("D first done", d1, 40);
        check("D second done", d2, 80);
        check("D busy drops", drops, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        loop_en = 1'b0;

        // Reset mid-message with start held high.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n == 17) begin
                check("E letter4", int'(letter_a), 4);
                rst = 1'b1;
                start = 1'b1;
            end
        end
        step();
        check("E rst letter", int'(letter_a), 0);
        check("E rst valid", int'(valid_a), 0);
        check("E rst busy", int'(busy_a), 0);
        check("E rst done", int'(done_a), 0);
        rst = 1'b0;
        step();
        check("E restart letter", int'(letter_a), 0);
        check("E restart valid", int'(valid_a), 1);
        check("E restart busy", int'(busy_a), 1);
        start = 1'b0;

        // Randomized traffic, checked by the per-cycle model.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 99) < 2);
            pause = ($urandom_range(0, 99) < 10);
            start = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 49) == 0) loop_en = $urandom_range(0, 1);
            step();
        end
        rst = 1'b0; abort = 1'b0; pause = 1'b0; start = 1'b0;
        step();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
